// File: rtl/autosa_unit_done_intr_gen_if.sv
// Bundled unit-side handshake for the done-interrupt generator: datapath done, DMA write
// request/ack, and the GLB-facing interrupt/status outputs.
interface autosa_unit_done_intr_gen_if;
   logic       dp_done;
   logic       dp_done_grp;
   logic       wr_req_vld;
   logic       wr_req_rdy;
   logic       wr_req_grp;
   logic       wr_rsp;
   logic       wr_rsp_grp;
   logic [1:0] done_intr_pd;
   logic [1:0] grp_busy;
   logic       intr_err;
   logic [7:0] intr_cnt0;
   logic [7:0] intr_cnt1;

   // Unit datapath / DMA side
   modport master (
      output dp_done, dp_done_grp, wr_req_vld, wr_req_grp, wr_rsp, wr_rsp_grp,
      input  wr_req_rdy, done_intr_pd, grp_busy, intr_err, intr_cnt0, intr_cnt1
   );

   // Interrupt generator side
   modport slave (
      input  dp_done, dp_done_grp, wr_req_vld, wr_req_grp, wr_rsp, wr_rsp_grp,
      output wr_req_rdy, done_intr_pd, grp_busy, intr_err, intr_cnt0, intr_cnt1
   );
endinterface

// File: rtl/autosa_unit_done_intr_gen.sv
// Per-unit done-interrupt source for the two ping-pong register groups into GLB.
// Optional per-group interrupt counters are built when AUTOSA_INTR_CNT_EN is defined.
module autosa_unit_done_intr_gen #(
   parameter int unsigned CNT_W = 14
) (
   input  logic                           autosa_core_clk,
   input  logic                           autosa_core_rstn,
   autosa_unit_done_intr_gen_if.slave     io_bus
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           r_state [2];
   state_e           w_state_nxt [2];
   logic [CNT_W-1:0] r_cnt [2];
   logic [CNT_W-1:0] w_cnt_nxt [2];
   logic             r_last_grp;
   logic             w_last_nxt;
   logic [1:0]       r_pd;
   logic [1:0]       r_busy;
   logic [1:0]       w_busy_nxt;
   logic             r_err;
   logic             w_err_set;

   logic             w_rdy;
   logic             w_acc;
   logic [1:0]       w_inc;
   logic [1:0]       w_dec;
   logic [1:0]       w_done;
   logic [1:0]       w_req;
   logic [1:0]       w_gnt;

   // Per-group decode of the single-port request/ack/done inputs
   assign w_rdy  = (r_cnt[io_bus.wr_req_grp] != CNT_MAX);
   assign w_acc  = io_bus.wr_req_vld & w_rdy;
   assign w_inc  = {w_acc & io_bus.wr_req_grp, w_acc & ~io_bus.wr_req_grp};
   assign w_dec  = {io_bus.wr_rsp & io_bus.wr_rsp_grp, io_bus.wr_rsp & ~io_bus.wr_rsp_grp};
   assign w_done = {io_bus.dp_done & io_bus.dp_done_grp, io_bus.dp_done & ~io_bus.dp_done_grp};

   assign w_req = {(r_state[1] == ST_WAIT) && (r_cnt[1] == '0),
                   (r_state[0] == ST_WAIT) && (r_cnt[0] == '0)};

   // One grant per cycle; a tie goes to the group not granted last
   always_comb begin
      w_gnt = 2'b00;
      case (w_req)
         2'b01:   w_gnt = 2'b01;
         2'b10:   w_gnt = 2'b10;
         2'b11:   w_gnt = r_last_grp ? 2'b01 : 2'b10;
         default: w_gnt = 2'b00;
      endcase
   end

   always_comb begin
      w_err_set  = 1'b0;
      w_last_nxt = r_last_grp;
      w_busy_nxt = 2'b00;
      for (int g = 0; g < 2; g++) begin
         w_state_nxt[g] = r_state[g];
         w_cnt_nxt[g]   = r_cnt[g];
      end

      for (int g = 0; g < 2; g++) begin
         if (r_state[g] == ST_IDLE) begin
            if (w_done[g]) w_state_nxt[g] = ST_WAIT;
         end else begin
            if (w_gnt[g]) w_state_nxt[g] = ST_IDLE;
            if (w_done[g] || w_inc[g]) w_err_set = 1'b1;
         end

         // Accept and ack to the same group in one cycle cancel out
         if (w_inc[g] && !w_dec[g]) begin
            w_cnt_nxt[g] = r_cnt[g] + CNT_W'(1);
         end else if (!w_inc[g] && w_dec[g]) begin
            if (r_cnt[g] != '0) w_cnt_nxt[g] = r_cnt[g] - CNT_W'(1);
            else                w_err_set    = 1'b1;
         end

         w_busy_nxt[g] = (r_state[g] == ST_WAIT) || (w_state_nxt[g] == ST_WAIT) ||
                         (r_cnt[g] != '0) || (w_cnt_nxt[g] != '0);
      end

      if (w_gnt != 2'b00) w_last_nxt = w_gnt[1];
   end

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         for (int g = 0; g < 2; g++) begin
            r_state[g] <= ST_IDLE;
            r_cnt[g]   <= '0;
         end
         r_last_grp <= 1'b1;
         r_pd       <= 2'b00;
         r_busy     <= 2'b00;
         r_err      <= 1'b0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            r_state[g] <= w_state_nxt[g];
            r_cnt[g]   <= w_cnt_nxt[g];
         end
         r_last_grp <= w_last_nxt;
         r_pd       <= w_gnt;
         r_busy     <= w_busy_nxt;
         r_err      <= r_err | w_err_set;
      end
   end

   assign io_bus.wr_req_rdy   = w_rdy;
   assign io_bus.done_intr_pd = r_pd;
   assign io_bus.grp_busy     = r_busy;
   assign io_bus.intr_err     = r_err;

`ifdef AUTOSA_INTR_CNT_EN
   logic [7:0] r_intr_cnt0;
   logic [7:0] r_intr_cnt1;

   // Saturating count of pulses issued per group
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         r_intr_cnt0 <= 8'h0;
         r_intr_cnt1 <= 8'h0;
      end else begin
         if (r_pd[0] && (r_intr_cnt0 != 8'hFF)) r_intr_cnt0 <= r_intr_cnt0 + 8'd1;
         if (r_pd[1] && (r_intr_cnt1 != 8'hFF)) r_intr_cnt1 <= r_intr_cnt1 + 8'd1;
      end
   end

   assign io_bus.intr_cnt0 = r_intr_cnt0;
   assign io_bus.intr_cnt1 = r_intr_cnt1;
`else
   assign io_bus.intr_cnt0 = 8'h0;
   assign io_bus.intr_cnt1 = 8'h0;
`endif

endmodule

// File: tb/tb_autosa_unit_done_intr_gen.sv
// Directed bench for autosa_unit_done_intr_gen: latency, ack gating, arbitration,
// error/backpressure, mid-operation reset and interrupt counting.
module tb_autosa_unit_done_intr_gen;

   localparam int unsigned CNT_W   = 14;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rstn;
   int   n_chk;
   int   n_err;
   logic saw11;

   autosa_unit_done_intr_gen_if bus ();

   autosa_unit_done_intr_gen #(.CNT_W(CNT_W)) dut (
      .autosa_core_clk  (clk),
      .autosa_core_rstn (rstn),
      .io_bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The two pulse bits must never be high together
   always @(negedge clk) if (bus.done_intr_pd === 2'b11) saw11 = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_done(input logic grp);
      bus.dp_done     = 1'b1;
      bus.dp_done_grp = grp;
      tick();
      bus.dp_done     = 1'b0;
   endtask

   task automatic pulse_rsp(input logic grp);
      bus.wr_rsp     = 1'b1;
      bus.wr_rsp_grp = grp;
      tick();
      bus.wr_rsp     = 1'b0;
   endtask

   task automatic writes(input logic grp, input int n);
      bus.wr_req_vld = 1'b1;
      bus.wr_req_grp = grp;
      repeat (n) tick();
      bus.wr_req_vld = 1'b0;
   endtask

   // Drives both groups into a request in the same cycle; returns pd two and three cycles later
   task automatic both_req(output logic [1:0] p_first, output logic [1:0] p_second,
                           output logic [1:0] p_before, output logic [1:0] p_after);
      writes(1'b0, 1);
      pulse_done(1'b0);
      bus.dp_done     = 1'b1;
      bus.dp_done_grp = 1'b1;
      bus.wr_rsp      = 1'b1;
      bus.wr_rsp_grp  = 1'b0;
      tick();
      bus.dp_done     = 1'b0;
      bus.wr_rsp      = 1'b0;
      p_before = bus.done_intr_pd;
      tick();
      p_first = bus.done_intr_pd;
      tick();
      p_second = bus.done_intr_pd;
      tick();
      p_after = bus.done_intr_pd;
   endtask

   initial begin
      logic       early;
      logic [1:0] p1, p2, p0, p3;
      int         pulses;
      logic [7:0] exp_cnt_full;
      logic [7:0] exp_cnt_two;

`ifdef AUTOSA_INTR_CNT_EN
      exp_cnt_full = 8'd255;
      exp_cnt_two  = 8'd2;
`else
      exp_cnt_full = 8'd0;
      exp_cnt_two  = 8'd0;
`endif

      n_chk = 0;
      n_err = 0;
      saw11 = 1'b0;
      rstn  = 1'b0;
      bus.dp_done = 1'b0; bus.dp_done_grp = 1'b0;
      bus.wr_req_vld = 1'b0; bus.wr_req_grp = 1'b0;
      bus.wr_rsp = 1'b0; bus.wr_rsp_grp = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_pd",   32'(bus.done_intr_pd), 32'h0);
      chk("rst_busy", 32'(bus.grp_busy),     32'h0);
      chk("rst_err",  32'(bus.intr_err),     32'h0);
      chk("rst_rdy",  32'(bus.wr_req_rdy),   32'h1);
      chk("rst_ic0",  32'(bus.intr_cnt0),    32'h0);
      chk("rst_ic1",  32'(bus.intr_cnt1),    32'h0);
      rstn = 1'b1;
      tick();

      // T1: done with nothing outstanding -> pulse two cycles later
      pulse_done(1'b0);
      chk("t1_pd_n1",   32'(bus.done_intr_pd), 32'h0);
      chk("t1_busy_n1", 32'(bus.grp_busy),     32'h1);
      tick();
      chk("t1_pd_n2",   32'(bus.done_intr_pd), 32'h1);
      chk("t1_busy_n2", 32'(bus.grp_busy),     32'h1);
      tick();
      chk("t1_pd_n3",   32'(bus.done_intr_pd), 32'h0);
      chk("t1_busy_n3", 32'(bus.grp_busy),     32'h0);

      // T2: pulse waits for the last of three acks
      writes(1'b1, 3);
      pulse_done(1'b1);
      chk("t2_busy", 32'(bus.grp_busy), 32'h2);
      early = 1'b0;
      for (int k = 0; k < 3; k++) begin
         repeat (4) begin
            tick();
            early |= (bus.done_intr_pd != 2'b00);
         end
         pulse_rsp(1'b1);
         early |= (bus.done_intr_pd != 2'b00);
      end
      chk("t2_no_early", 32'(early), 32'h0);
      tick();
      chk("t2_pd_m2", 32'(bus.done_intr_pd), 32'h2);
      tick();
      chk("t2_pd_m3", 32'(bus.done_intr_pd), 32'h0);
      chk("t2_err",   32'(bus.intr_err),     32'h0);

      // T3: simultaneous requests, last grant was group 1 -> group 0 first
      both_req(p1, p2, p0, p3);
      chk("t3_before", 32'(p0), 32'h0);
      chk("t3_first",  32'(p1), 32'h1);
      chk("t3_second", 32'(p2), 32'h2);
      chk("t3_after",  32'(p3), 32'h0);

      // T3b: last grant group 0 -> group 1 wins the tie
      pulse_done(1'b0);
      repeat (2) tick();
      both_req(p1, p2, p0, p3);
      chk("t3b_first",  32'(p1), 32'h2);
      chk("t3b_second", 32'(p2), 32'h1);
      chk("t3b_err",    32'(bus.intr_err), 32'h0);

      // T4: spurious ack sets sticky error, counter does not underflow
      pulse_rsp(1'b0);
      chk("t4_err",  32'(bus.intr_err),     32'h1);
      chk("t4_pd",   32'(bus.done_intr_pd), 32'h0);
      tick();
      chk("t4_err_sticky", 32'(bus.intr_err), 32'h1);
      chk("t4_busy",       32'(bus.grp_busy), 32'h0);

      // T4: fill group 1 counter to its maximum
      bus.wr_req_vld = 1'b1;
      bus.wr_req_grp = 1'b1;
      repeat (CNT_MAX - 1) tick();
      chk("t4_rdy_max_m1", 32'(bus.wr_req_rdy), 32'h1);
      tick();
      chk("t4_rdy_full", 32'(bus.wr_req_rdy), 32'h0);
      bus.wr_req_grp = 1'b0;
      #1;
      chk("t4_rdy_grp0", 32'(bus.wr_req_rdy), 32'h1);
      bus.wr_req_grp = 1'b1;
      repeat (3) tick();
      chk("t4_rdy_nowrap", 32'(bus.wr_req_rdy), 32'h0);
      bus.wr_req_vld = 1'b0;
      pulse_rsp(1'b1);
      #1;
      chk("t4_rdy_after_ack", 32'(bus.wr_req_rdy), 32'h1);

      // T5: reset while group 0 waits on two writes
      writes(1'b0, 2);
      pulse_done(1'b0);
      chk("t5_busy_pre", 32'(bus.grp_busy), 32'h3);
      rstn = 1'b0;
      #1;
      chk("t5_rst_pd",   32'(bus.done_intr_pd), 32'h0);
      chk("t5_rst_busy", 32'(bus.grp_busy),     32'h0);
      chk("t5_rst_err",  32'(bus.intr_err),     32'h0);
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      early = 1'b0;
      pulse_rsp(1'b0);
      early |= (bus.done_intr_pd != 2'b00);
      pulse_rsp(1'b0);
      early |= (bus.done_intr_pd != 2'b00);
      repeat (4) begin
         tick();
         early |= (bus.done_intr_pd != 2'b00);
      end
      chk("t5_no_pulse", 32'(early),        32'h0);
      chk("t5_busy",     32'(bus.grp_busy), 32'h0);

      // T6: 300 group-0 interrupts, counter saturates
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         pulse_done(1'b0);
         tick();
         if (bus.done_intr_pd == 2'b01) pulses++;
         if (i == 2) chk("t6_ic0_two", 32'(bus.intr_cnt0), 32'(exp_cnt_two));
      end
      tick();
      chk("t6_pulses", 32'(pulses),          32'd300);
      chk("t6_ic0",    32'(bus.intr_cnt0),   32'(exp_cnt_full));
      chk("t6_ic1",    32'(bus.intr_cnt1),   32'h0);
      chk("no_pd_11",  32'(saw11),           32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
